// File: rtl/spi_regfile_peripheral.sv
// ---------------------------------------------------------------------------
// spi_regfile_peripheral
// SPI mode-0 slave front-end in front of a NUM_REGS x DATA_W config register
// file. SCLK/COPI/nCS are asynchronous and pass through 2-FF synchronisers;
// everything else runs on clk. Frames (MSB first: R/W, addr, data) are only
// validated and committed when nCS deasserts.
//
// Optional feature macro: SPI_READBACK_EN
//   defined   : read frames return reg[addr] on CIPO (0 for unmapped addr)
//   undefined : CIPO tied 0, read frames are length-checked only
//
// Ports
//   clk        system clock (>= 8x SCLK)
//   rst_n      async active-low reset
//   SCLK       SPI clock (async)
//   COPI       SPI data from controller (async)
//   nCS        SPI chip select, active-low (async)
//   CIPO       SPI data to controller
//   regs_out   flat register file, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe  one-clk pulse on bit k when reg k is written
//   frame_err  one-clk pulse when a frame is discarded for bad length
// ---------------------------------------------------------------------------
module spi_regfile_peripheral #(
   parameter int unsigned ADDR_W   = 7,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_REGS = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       SCLK,
   input  logic                       COPI,
   input  logic                       nCS,
   output logic                       CIPO,
   output logic [NUM_REGS*DATA_W-1:0] regs_out,
   output logic [NUM_REGS-1:0]        wr_strobe,
   output logic                       frame_err
);

   localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
   localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 2);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(1 + ADDR_W);

   typedef enum logic [1:0] {
      ST_WAIT_IDLE,
      ST_IDLE,
      ST_ACTIVE,
      ST_COMMIT
   } state_e;

   state_e                            state_q, state_d;
   logic [2:0]                        sclk_sync_q, sclk_sync_d;
   logic [2:0]                        ncs_sync_q, ncs_sync_d;
   logic [1:0]                        copi_sync_q, copi_sync_d;
   logic [1:0]                        settle_q, settle_d;
   logic [FRAME_LEN-1:0]              shift_q, shift_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
   logic [NUM_REGS-1:0]               wr_strobe_q, wr_strobe_d;
   logic                              frame_err_q, frame_err_d;

   logic                              sclk_rise;
   logic                              ncs_rise;
   logic                              ncs_lvl;
   logic [FRAME_LEN-1:0]              shift_in;
   logic                              frame_wr;
   logic [ADDR_W-1:0]                 frame_addr;
   logic [DATA_W-1:0]                 frame_data;

`ifdef SPI_READBACK_EN
   logic [DATA_W-1:0]                 out_shift_q, out_shift_d;
   logic                              cipo_q, cipo_d;
   logic                              sclk_fall;
   logic [DATA_W-1:0]                 rd_data;
`endif

   // Edge/level detection on the synchronised pins (FF2 vs FF3)
   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign ncs_rise  = ncs_sync_q[1]  & ~ncs_sync_q[2];
   assign ncs_lvl   = ncs_sync_q[1];
   assign shift_in  = {shift_q[FRAME_LEN-2:0], copi_sync_q[1]};

   assign frame_wr   = shift_q[FRAME_LEN-1];
   assign frame_addr = shift_q[FRAME_LEN-2 -: ADDR_W];
   assign frame_data = shift_q[DATA_W-1:0];

`ifdef SPI_READBACK_EN
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

   // Register lookup for the address just completed in the incoming frame
   always_comb begin
      rd_data = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (shift_in[ADDR_W-1:0] == ADDR_W'(k)) begin
            rd_data = regs_q[k];
         end
      end
   end
`endif

   // Next-state / datapath
   always_comb begin
      state_d     = state_q;
      sclk_sync_d = {sclk_sync_q[1:0], SCLK};
      ncs_sync_d  = {ncs_sync_q[1:0], nCS};
      copi_sync_d = {copi_sync_q[0], COPI};
      settle_d    = settle_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      regs_d      = regs_q;
      wr_strobe_d = '0;
      frame_err_d = 1'b0;
`ifdef SPI_READBACK_EN
      out_shift_d = out_shift_q;
      cipo_d      = cipo_q;
`endif

      unique case (state_q)
         // Synchroniser outputs hold reset values for a few clocks, so let
         // them flush before trusting nCS; a frame cut by reset is skipped.
         ST_WAIT_IDLE: begin
`ifdef SPI_READBACK_EN
            cipo_d = 1'b0;
`endif
            if (settle_q != 2'd3) begin
               settle_d = settle_q + 2'd1;
            end else if (ncs_lvl) begin
               state_d = ST_IDLE;
            end
         end

         // Level-sensitive so a reassert during COMMIT is still caught here
         ST_IDLE: begin
`ifdef SPI_READBACK_EN
            cipo_d = 1'b0;
`endif
            if (!ncs_lvl) begin
               state_d = ST_ACTIVE;
               shift_d = '0;
               cnt_d   = '0;
`ifdef SPI_READBACK_EN
               out_shift_d = '0;
`endif
            end
         end

         // nCS rise wins over a coincident SCLK rise, which is dropped
         ST_ACTIVE: begin
            if (ncs_rise) begin
               state_d = ST_COMMIT;
`ifdef SPI_READBACK_EN
               cipo_d  = 1'b0;
`endif
            end else if (sclk_rise) begin
               shift_d = shift_in;
               if (cnt_q != CNT_SAT) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`ifdef SPI_READBACK_EN
               if ((cnt_q == CNT_HDR - CNT_W'(1)) && !shift_in[ADDR_W]) begin
                  out_shift_d = rd_data;
               end
`endif
            end
`ifdef SPI_READBACK_EN
            else if (sclk_fall) begin
               cipo_d      = out_shift_q[DATA_W-1];
               out_shift_d = {out_shift_q[DATA_W-2:0], 1'b0};
            end
`endif
         end

         ST_COMMIT: begin
            state_d = ST_IDLE;
`ifdef SPI_READBACK_EN
            cipo_d  = 1'b0;
`endif
            if (cnt_q != CNT_FULL) begin
               frame_err_d = 1'b1;
            end else if (frame_wr) begin
               for (int unsigned k = 0; k < NUM_REGS; k++) begin
                  if (frame_addr == ADDR_W'(k)) begin
                     regs_d[k]      = frame_data;
                     wr_strobe_d[k] = 1'b1;
                  end
               end
            end
         end

         default: state_d = ST_WAIT_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_WAIT_IDLE;
         sclk_sync_q <= '0;
         ncs_sync_q  <= '1;
         copi_sync_q <= '0;
         settle_q    <= '0;
         shift_q     <= '0;
         cnt_q       <= '0;
         regs_q      <= '0;
         wr_strobe_q <= '0;
         frame_err_q <= 1'b0;
`ifdef SPI_READBACK_EN
         out_shift_q <= '0;
         cipo_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         ncs_sync_q  <= ncs_sync_d;
         copi_sync_q <= copi_sync_d;
         settle_q    <= settle_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         regs_q      <= regs_d;
         wr_strobe_q <= wr_strobe_d;
         frame_err_q <= frame_err_d;
`ifdef SPI_READBACK_EN
         out_shift_q <= out_shift_d;
         cipo_q      <= cipo_d;
`endif
      end
   end

   assign regs_out  = regs_q;
   assign wr_strobe = wr_strobe_q;
   assign frame_err = frame_err_q;
`ifdef SPI_READBACK_EN
   assign CIPO      = cipo_q;
`else
   assign CIPO      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// ---------------------------------------------------------------------------
// tb_spi_regfile_peripheral
// Self-checking bench: a table of directed frames, hand-written corner
// sequences (reset mid-frame, coincident SCLK/nCS rise, back-to-back frames)
// and random frames checked against a register-array reference model.
// ---------------------------------------------------------------------------
module tb_spi_regfile_peripheral;

   localparam int unsigned NUM_REGS  = 5;
   localparam int unsigned FRAME_LEN = 16;
   localparam int          HALF      = 8;   // clk cycles per SCLK half period
   localparam int          GAP       = 16;  // clk cycles nCS stays high between frames

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    sclk;
   logic                    copi;
   logic                    ncs;
   logic                    cipo;
   logic [NUM_REGS*8-1:0]   regs_out;
   logic [NUM_REGS-1:0]     wr_strobe;
   logic                    frame_err;

   always #5 clk = ~clk;

   spi_regfile_peripheral dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .SCLK      (sclk),
      .COPI      (copi),
      .nCS       (ncs),
      .CIPO      (cipo),
      .regs_out  (regs_out),
      .wr_strobe (wr_strobe),
      .frame_err (frame_err)
   );

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0]          model [NUM_REGS];
   logic [NUM_REGS-1:0] strobe_or;
   int                  strobe_cyc;
   int                  err_cyc;
   int                  onehot_bad = 0;

   // Pulse monitor, sampled away from the active edge
   always @(negedge clk) begin
      strobe_or = strobe_or | wr_strobe;
      if (wr_strobe != '0) strobe_cyc = strobe_cyc + 1;
      if (frame_err)       err_cyc    = err_cyc + 1;
      if (!$onehot0(wr_strobe)) onehot_bad = onehot_bad + 1;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_miss = n_miss + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_mon();
      strobe_or  = '0;
      strobe_cyc = 0;
      err_cyc    = 0;
   endtask

   function automatic logic [NUM_REGS*8-1:0] packed_model();
      logic [NUM_REGS*8-1:0] p;
      p = '0;
      for (int k = 0; k < NUM_REGS; k++) p[k*8 +: 8] = model[k];
      return p;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
   endfunction

   // word holds the frame left-justified: bit k (1-based, MSB first) at word[32-k]
   function automatic void model_apply(input logic [31:0] word, input int nbits);
      if (nbits == FRAME_LEN && word[31] && (int'(word[30:24]) < NUM_REGS))
         model[int'(word[30:24])] = word[23:16];
   endfunction

   function automatic logic [NUM_REGS-1:0] model_strobe(input logic [31:0] word, input int nbits);
      logic [NUM_REGS-1:0] s;
      s = '0;
      if (nbits == FRAME_LEN && word[31] && (int'(word[30:24]) < NUM_REGS))
         s[int'(word[30:24])] = 1'b1;
      return s;
   endfunction

   // CIPO seen just before each SCLK rise: data MSB-first on rises 9..16 of a read
   function automatic logic [31:0] expected_cipo(input logic [31:0] word, input int nbits);
      logic [31:0] e;
      logic [7:0]  rd;
      logic        rb_en;
`ifdef SPI_READBACK_EN
      rb_en = 1'b1;
`else
      rb_en = 1'b0;
`endif
      e  = '0;
      rd = (int'(word[30:24]) < NUM_REGS) ? model[int'(word[30:24])] : 8'h00;
      if (rb_en && !word[31]) begin
         for (int k = 9; k <= 16; k++)
            if (k <= nbits) e[32-k] = rd[16-k];
      end
      return e;
   endfunction

   task automatic shift_bits(input logic [31:0] word, input int first, input int last,
                             input logic [31:0] cap_in, output logic [31:0] cap_out);
      cap_out = cap_in;
      for (int k = first; k <= last; k++) begin
         copi = word[32-k];
         wait_clk(HALF);
         cap_out[32-k] = cipo;
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [31:0] word, input int nbits, output logic [31:0] cap);
      logic [31:0] c;
      ncs = 1'b0;
      shift_bits(word, 1, nbits, 32'h0, c);
      cap = c;
      wait_clk(HALF);
      ncs  = 1'b1;
      copi = 1'b0;
      wait_clk(GAP);
   endtask

   task automatic do_frame(input string tag, input logic [31:0] value, input int nbits,
                           input logic [NUM_REGS-1:0] exp_strobe, input logic exp_err);
      logic [31:0] word, cap, exp_cap;
      word    = value << (32 - nbits);
      exp_cap = expected_cipo(word, nbits);
      clear_mon();
      send_frame(word, nbits, cap);
      model_apply(word, nbits);
      check({tag, " strobe"},     64'(strobe_or),  64'(exp_strobe));
      check({tag, " strobe_len"}, 64'(strobe_cyc), 64'((exp_strobe != '0) ? 1 : 0));
      check({tag, " frame_err"},  64'(err_cyc),    64'(exp_err ? 1 : 0));
      check({tag, " regs"},       64'(regs_out),   64'(packed_model()));
      check({tag, " cipo"},       64'(cap),        64'(exp_cap));
      check({tag, " cipo_idle"},  64'(cipo),       64'h0);
   endtask

   typedef struct {
      string               tag;
      logic [31:0]         value;
      int                  nbits;
      logic [NUM_REGS-1:0] exp_strobe;
      logic                exp_err;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [31:0]         word, cap;
      logic [NUM_REGS-1:0] es;
      int                  nb, r;
      logic [31:0]         v;

      vecs[0] = '{"wr_a1",    32'h81F0,  16, 5'b00010, 1'b0};
      vecs[1] = '{"short15",  32'h40F8,  15, 5'b00000, 1'b1};
      vecs[2] = '{"long17",   32'h181F1, 17, 5'b00000, 1'b1};
      vecs[3] = '{"unmapped", 32'h90AA,  16, 5'b00000, 1'b0};
      vecs[4] = '{"wr_a2",    32'h82A5,  16, 5'b00100, 1'b0};
      vecs[5] = '{"rd_a2",    32'h0200,  16, 5'b00000, 1'b0};

      model_reset();
      clear_mon();
      sclk  = 1'b0;
      copi  = 1'b0;
      ncs   = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      wait_clk(3);
      check("rst regs",      64'(regs_out),  64'h0);
      check("rst strobe",    64'(wr_strobe), 64'h0);
      check("rst frame_err", 64'(frame_err), 64'h0);
      check("rst cipo",      64'(cipo),      64'h0);
      rst_n = 1'b1;
      wait_clk(8);

      // Directed table
      for (int i = 0; i < 6; i++)
         do_frame(vecs[i].tag, vecs[i].value, vecs[i].nbits, vecs[i].exp_strobe, vecs[i].exp_err);

      // Reset in the middle of 0x83C3, released with nCS still low
      word = 32'h83C3 << 16;
      clear_mon();
      ncs = 1'b0;
      shift_bits(word, 1, 8, 32'h0, cap);
      rst_n = 1'b0;
      #3;
      model_reset();
      check("midrst regs",   64'(regs_out),  64'h0);
      check("midrst strobe", 64'(wr_strobe), 64'h0);
      wait_clk(3);
      rst_n = 1'b1;
      clear_mon();
      shift_bits(word, 9, 16, cap, cap);
      wait_clk(HALF);
      ncs  = 1'b1;
      copi = 1'b0;
      wait_clk(GAP);
      check("midrst no_write", 64'(strobe_cyc), 64'h0);
      check("midrst no_err",   64'(err_cyc),    64'h0);
      check("midrst regs2",    64'(regs_out),   64'(packed_model()));
      do_frame("wr_a3", 32'h83C3, 16, 5'b01000, 1'b0);

      // 17th SCLK rise lands in the same clock as the nCS rise: not counted
      word = 32'h8155 << 16;
      clear_mon();
      ncs = 1'b0;
      shift_bits(word, 1, 16, 32'h0, cap);
      copi = 1'b1;
      wait_clk(HALF);
      sclk = 1'b1;
      ncs  = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      copi = 1'b0;
      wait_clk(GAP);
      model_apply(word, 16);
      check("coinc strobe", 64'(strobe_or), 64'h02);
      check("coinc err",    64'(err_cyc),   64'h0);
      check("coinc regs",   64'(regs_out),  64'(packed_model()));

      // Back-to-back writes, nCS high for one SCLK period in between
      clear_mon();
      send_frame(32'h8011 << 16, 16, cap);
      send_frame(32'h8422 << 16, 16, cap);
      model_apply(32'h8011 << 16, 16);
      model_apply(32'h8422 << 16, 16);
      check("b2b strobe",     64'(strobe_or),  64'h11);
      check("b2b strobe_len", 64'(strobe_cyc), 64'h2);
      check("b2b err",        64'(err_cyc),    64'h0);
      check("b2b regs",       64'(regs_out),   64'(packed_model()));

      // Random frames against the model
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)       nb = 16;
         else if (r == 7) nb = 15;
         else if (r == 8) nb = 17;
         else             nb = int'($urandom_range(1, 24));
         v = $urandom;
         if (nb == 16) begin
            v = {16'h0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
            if ($urandom_range(0, 7) == 0) v[14:8] = 7'($urandom);
         end else begin
            v = v & ((32'h1 << nb) - 32'h1);
         end
         word = v << (32 - nb);
         es   = model_strobe(word, nb);
         do_frame("rand", v, nb, es, (nb != FRAME_LEN));
      end

      check("strobe onehot", 64'(onehot_bad), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
